mem_port_arbiter: RTL

- Shares one single-port memory bus between the core's instruction-fetch port (IF stage) and data port (MEM stage) of the 5-stage MIPS pipeline.
- Sits between the core and a unified instruction/data memory.
- Sequences one bus transaction at a time with a req/ack handshake, and returns per-port stall signals; the core freezes its whole pipeline while either stall is high.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Core/memory signal bundle for mem_port_arbiter. The master modport is the arbiter's view;
// the slave modport is the view of the core and memory it connects.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              inst_ren;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_data;
    logic              inst_stall;
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_din;
    logic              mem_stall;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, bus_rdata, bus_ack,
        output inst_data, inst_stall, mem_din, mem_stall, bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, bus_rdata, bus_ack,
        input  inst_data, inst_stall, mem_din, mem_stall, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM stage accesses onto one memory bus, data first, with per-port stalls.
// Optional statistics counters are enabled with `define MEM_ARB_STAT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.master    arb
`ifdef MEM_ARB_STAT_EN
    ,
    output logic [31:0]           stat_inst_cnt,
    output logic [31:0]           stat_data_cnt,
    output logic [31:0]           stat_stall_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StDataBusy, StInstBusy} state_e;

    state_e            state_q, state_d;
    logic              inst_done_q, inst_done_d;
    logic              data_done_q, data_done_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] inst_data_q, inst_data_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;

    logic data_req, inst_req, inst_stall, mem_stall, advance;

    assign data_req   = arb.mem_ren | arb.mem_wen;
    assign inst_req   = arb.inst_ren;
    assign inst_stall = inst_req & ~inst_done_q;
    assign mem_stall  = data_req & ~data_done_q;
    assign advance    = ~inst_stall & ~mem_stall;

    always_comb begin
        state_d     = state_q;
        inst_done_d = inst_done_q;
        data_done_d = data_done_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        inst_data_d = inst_data_q;
        mem_din_d   = mem_din_q;

        if (advance) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Data wins: the MEM stage holds the older instruction.
                if (mem_stall) begin
                    bus_addr_d  = arb.mem_addr;
                    bus_wdata_d = arb.mem_dout;
                    bus_we_d    = arb.mem_wen;
                    state_d     = StDataBusy;
                end else if (inst_stall) begin
                    bus_addr_d = arb.inst_addr;
                    bus_we_d   = 1'b0;
                    state_d    = StInstBusy;
                end
            end
            StDataBusy: begin
                if (arb.bus_ack) begin
                    data_done_d = 1'b1;
                    if (!bus_we_q) mem_din_d = arb.bus_rdata;
                    state_d = StIdle;
                end
            end
            StInstBusy: begin
                if (arb.bus_ack) begin
                    inst_done_d = 1'b1;
                    inst_data_d = arb.bus_rdata;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            inst_data_q <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            inst_done_q <= inst_done_d;
            data_done_q <= data_done_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            inst_data_q <= inst_data_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign arb.bus_req    = (state_q != StIdle);
    assign arb.bus_we     = bus_we_q;
    assign arb.bus_addr   = bus_addr_q;
    assign arb.bus_wdata  = bus_wdata_q;
    assign arb.inst_data  = inst_data_q;
    assign arb.mem_din    = mem_din_q;
    assign arb.inst_stall = inst_stall;
    assign arb.mem_stall  = mem_stall;

`ifdef MEM_ARB_STAT_EN
    logic [31:0] stat_inst_q, stat_data_q, stat_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_inst_q  <= '0;
            stat_data_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (state_q == StInstBusy && arb.bus_ack) stat_inst_q <= stat_inst_q + 32'd1;
            if (state_q == StDataBusy && arb.bus_ack) stat_data_q <= stat_data_q + 32'd1;
            if (inst_stall | mem_stall) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_inst_cnt  = stat_inst_q;
    assign stat_data_cnt  = stat_data_q;
    assign stat_stall_cnt = stat_stall_q;
`endif

endmodule
